snurisc_icache: RTL and testbench

Direct-mapped, read-only instruction cache that answers fetch requests issued by the `frontend` block and refills lines from instruction memory on a miss. It sits between `frontend` and the memory port in `snurisc_top` and is the responder side of the frontend's request/read-not-write fetch interface. Write requests (`i_rnw`=0) do not store data; they invalidate the matching line, for example after a fence or self-modifying code.

---
 rtl/snurisc_icache_if.sv | 27 ++
 rtl/snurisc_icache.sv | 129 ++++++++++++
 tb/tb_snurisc_icache.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/snurisc_icache_if.sv
// Fetch request/response and refill-memory signals shared by frontend, icache and instruction memory.
// slave = the cache side; master = the frontend/memory side that drives requests and refill beats.
interface snurisc_icache_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = AWIDTH
);
  logic              i_rq;
  logic              i_rnw;
  logic [AWIDTH-1:0] i_addr;
  logic              o_ready;
  logic              o_valid;
  logic [DWIDTH-1:0] o_inst;
  logic              o_mem_rq;
  logic [AWIDTH-1:0] o_mem_addr;
  logic              i_mem_valid;
  logic [DWIDTH-1:0] i_mem_data;

  modport slave (
    input  i_rq, i_rnw, i_addr, i_mem_valid, i_mem_data,
    output o_ready, o_valid, o_inst, o_mem_rq, o_mem_addr
  );

  modport master (
    output i_rq, i_rnw, i_addr, i_mem_valid, i_mem_data,
    input  o_ready, o_valid, o_inst, o_mem_rq, o_mem_addr
  );
endinterface

// File: rtl/snurisc_icache.sv
// Direct-mapped read-only icache: hit answers 1 cycle after accept (1/cycle sustained), miss refills a whole line.
// Backpressure: o_ready drops from a miss until the RESPOND cycle has passed; refill beats are paced by i_mem_valid.
module snurisc_icache #(
  parameter int AWIDTH     = 32,
  parameter int DWIDTH     = AWIDTH,
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4
) (
  input logic          i_clk,
  input logic          i_reset,
  snurisc_icache_if.slave bus
);
  localparam int WOB = $clog2(LINE_WORDS);
  localparam int IB  = $clog2(NUM_LINES);
  localparam int TB  = AWIDTH - 2 - WOB - IB;

  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESPOND} state_t;
  state_t state, state_nxt;

  logic [NUM_LINES-1:0] valid;
  logic [TB-1:0]        tags [NUM_LINES];
  logic [DWIDTH-1:0]    data [NUM_LINES][LINE_WORDS];

  // Request captured at accept; tag/valid/word are sampled then so a later invalidate cannot disturb it.
  logic [AWIDTH-3:0] addr_q;
  logic              l_valid;
  logic [TB-1:0]     l_tag;
  logic [DWIDTH-1:0] inst_q;
  logic [WOB-1:0]    cnt;

  logic ready, resp, mem_rq, accept, hit;

  logic [WOB-1:0] rq_wo;
  logic [IB-1:0]  rq_idx;
  logic [TB-1:0]  rq_tag;
  logic [WOB-1:0] q_wo;
  logic [IB-1:0]  q_idx;
  logic [TB-1:0]  q_tag;
  logic           unused_addr_bits;

  assign rq_wo  = bus.i_addr[2 +: WOB];
  assign rq_idx = bus.i_addr[2+WOB +: IB];
  assign rq_tag = bus.i_addr[AWIDTH-1 -: TB];
  assign q_wo   = addr_q[0 +: WOB];
  assign q_idx  = addr_q[WOB +: IB];
  assign q_tag  = addr_q[AWIDTH-3 -: TB];
  assign unused_addr_bits = &{1'b0, bus.i_addr[1:0]};

  assign hit    = l_valid && (l_tag == q_tag);
  assign accept = bus.i_rq && ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    resp      = 1'b0;
    mem_rq    = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.i_rq && bus.i_rnw) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          resp      = 1'b1;
          ready     = 1'b1;
          state_nxt = (bus.i_rq && bus.i_rnw) ? LOOKUP : IDLE;
        end else begin
          state_nxt = REFILL;
        end
      end
      REFILL: begin
        mem_rq = 1'b1;
        if (bus.i_mem_valid && (&cnt)) state_nxt = RESPOND;
      end
      RESPOND: begin
        resp      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (i_reset) begin
      ready  = 1'b0;
      resp   = 1'b0;
      mem_rq = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid   <= '0;
      l_valid <= 1'b0;
      inst_q  <= '0;
      cnt     <= '0;
    end else begin
      if (accept) begin
        if (bus.i_rnw) begin
          addr_q  <= bus.i_addr[AWIDTH-1:2];
          l_valid <= valid[rq_idx];
          l_tag   <= tags[rq_idx];
          inst_q  <= data[rq_idx][rq_wo];
        end else if (valid[rq_idx] && (tags[rq_idx] == rq_tag)) begin
          valid[rq_idx] <= 1'b0;
        end
      end
      if (state == LOOKUP && !hit) cnt <= '0;
      // Line becomes valid only on its final beat, so an abandoned refill leaves it invalid.
      if (state == REFILL && bus.i_mem_valid) begin
        data[q_idx][cnt] <= bus.i_mem_data;
        if (cnt == q_wo) inst_q <= bus.i_mem_data;
        cnt <= cnt + WOB'(1);
        if (&cnt) begin
          tags[q_idx]  <= q_tag;
          valid[q_idx] <= 1'b1;
        end
      end
    end
  end

  assign bus.o_ready    = ready;
  assign bus.o_valid    = resp;
  assign bus.o_inst     = i_reset ? '0 : inst_q;
  assign bus.o_mem_rq   = mem_rq;
  assign bus.o_mem_addr = mem_rq ? {addr_q[AWIDTH-3:WOB], cnt, 2'b00} : '0;
endmodule

// File: tb/tb_snurisc_icache.sv
// Cycle-by-cycle directed vectors for snurisc_icache: every cycle drives inputs and checks the outputs.
module tb_snurisc_icache;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  snurisc_icache_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

  snurisc_icache #(
    .AWIDTH(32), .DWIDTH(32), .NUM_LINES(16), .LINE_WORDS(4)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  typedef struct {
    logic        rst;
    logic        rq;
    logic        rnw;
    logic [31:0] addr;
    logic        mv;
    logic [31:0] md;
    logic        e_rdy;
    logic        e_vld;
    logic [31:0] e_inst;
    logic        e_mrq;
    logic [31:0] e_maddr;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  function automatic vec_t mk(input logic r, input logic rq, input logic rnw, input logic [31:0] addr,
                              input logic mv, input logic [31:0] md,
                              input logic e_rdy, input logic e_vld, input logic [31:0] e_inst,
                              input logic e_mrq, input logic [31:0] e_maddr);
    vec_t v;
    v.rst = r; v.rq = rq; v.rnw = rnw; v.addr = addr; v.mv = mv; v.md = md;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_inst = e_inst; v.e_mrq = e_mrq; v.e_maddr = e_maddr;
    return v;
  endfunction

  function automatic void add(input logic r, input logic rq, input logic rnw, input logic [31:0] addr,
                              input logic mv, input logic [31:0] md,
                              input logic e_rdy, input logic e_vld, input logic [31:0] e_inst,
                              input logic e_mrq, input logic [31:0] e_maddr);
    vecs.push_back(mk(r, rq, rnw, addr, mv, md, e_rdy, e_vld, e_inst, e_mrq, e_maddr));
  endfunction

  // Four back-to-back refill beats for the line at base, data d0..d0+3.
  function automatic void refill(input logic [31:0] base, input logic [31:0] d0);
    for (int b = 0; b < 4; b++)
      add(0, 0, 0, 0, 1, d0 + b, 0, 0, 0, 1, base + 32'(4 * b));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL cycle %0d %s: got %h expected %h", cyc, name, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    @(negedge clk);
    rst             = v.rst;
    bus.i_rq        = v.rq;
    bus.i_rnw       = v.rnw;
    bus.i_addr      = v.addr;
    bus.i_mem_valid = v.mv;
    bus.i_mem_data  = v.md;
    #1;
    check("o_ready", {31'b0, bus.o_ready}, {31'b0, v.e_rdy});
    check("o_valid", {31'b0, bus.o_valid}, {31'b0, v.e_vld});
    check("o_mem_rq", {31'b0, bus.o_mem_rq}, {31'b0, v.e_mrq});
    if (v.e_vld || v.rst) check("o_inst", bus.o_inst, v.e_inst);
    if (v.e_mrq || v.rst) check("o_mem_addr", bus.o_mem_addr, v.e_maddr);
    cyc++;
  endtask

  initial begin
    bus.i_rq = 1'b0; bus.i_rnw = 1'b0; bus.i_addr = '0;
    bus.i_mem_valid = 1'b0; bus.i_mem_data = '0;

    // reset
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // cold miss on 0x104: word 1 of the line returned
    add(0, 1, 1, 32'h104, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    refill(32'h100, 32'hA0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 32'hA1, 0, 0);
    // back-to-back hits; stray memory beat in IDLE is ignored
    add(0, 1, 1, 32'h100, 1, 32'hDEAD, 1, 0, 0, 0, 0);
    add(0, 1, 1, 32'h108, 0, 0, 1, 1, 32'hA0, 0, 0);
    add(0, 1, 1, 32'h10C, 0, 0, 1, 1, 32'hA2, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 32'hA3, 0, 0);
    // conflict miss: 0x204 evicts, then 0x104 misses again
    add(0, 1, 1, 32'h204, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    refill(32'h200, 32'hB0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 32'hB1, 0, 0);
    add(0, 1, 1, 32'h104, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    refill(32'h100, 32'hC0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 32'hC1, 0, 0);
    // invalidate 0x100 then read it next cycle: miss
    add(0, 1, 0, 32'h100, 1, 32'hBEEF, 1, 0, 0, 0, 0);
    add(0, 1, 1, 32'h100, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    refill(32'h100, 32'hD0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 32'hD0, 0, 0);
    // invalidate with tag mismatch leaves the line; then read-hit with a same-line invalidate alongside
    add(0, 1, 0, 32'h300, 0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 1, 32'h100, 0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 32'h100, 0, 0, 1, 1, 32'hD0, 0, 0);
    add(0, 1, 1, 32'h100, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // reset after two refill beats
    add(0, 0, 0, 0, 1, 32'hE0, 0, 0, 0, 1, 32'h100);
    add(0, 0, 0, 0, 1, 32'hE1, 0, 0, 0, 1, 32'h104);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 32'h100, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    refill(32'h100, 32'hF0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 32'hF0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // stalled memory: 3 idle cycles before every beat of the 0x400 line
    step(mk(0, 1, 1, 32'h408, 0, 0, 1, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < 3; g++)
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h400 + 32'(4 * b)));
      step(mk(0, 0, 0, 0, 1, 32'h1230 + 32'(b), 0, 0, 0, 1, 32'h400 + 32'(4 * b)));
    end
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h1232, 0, 0));
    step(mk(0, 1, 1, 32'h40C, 0, 0, 1, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h1233, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
